// File: rtl/ex_div_iter_pkg.sv
// rtl/ex_div_iter_pkg.sv - shared types and result layout for the iterative divider
//
// Purpose: FSM state encoding and the field order of the packed result word
// {remainder, quotient}. Field indices are multiplied by WIDTH at the use site,
// so a single definition serves every operand width.
// Ports: none (package).
package ex_div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Result word slot indices: slot k occupies bits [k*WIDTH +: WIDTH].
  localparam int DIV_QUO_FIELD = 0;
  localparam int DIV_REM_FIELD = 1;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division iteration
//
// Purpose: shift the next dividend bit into the partial remainder, trial-subtract
// the divisor and keep the difference only when it did not borrow.
// Ports:
//   rem_i      partial remainder (WIDTH+1 bits, top bit always 0 between steps)
//   dvd_bit_i  next dividend bit, MSB first
//   divisor_i  divisor magnitude
//   rem_o      updated partial remainder
//   quo_bit_o  quotient bit produced by this step
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted   = {rem_i, dvd_bit_i};
    trial     = shifted - {2'b00, divisor_i};
    // shifted < 2^(WIDTH+1), so the MSB of the difference is a clean borrow flag.
    quo_bit_o = ~trial[WIDTH+1];
    rem_o     = quo_bit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/ex_div_iter.sv
// rtl/ex_div_iter.sv - multi-cycle restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU
//
// Purpose: accepts a request in IDLE, runs WIDTH magnitude steps MSB first, applies
// sign correction on the last step and pulses done_o for one cycle with
// result_o = {remainder, quotient}. Divide-by-zero finishes after one step.
// Optional feature macro: DIV_EARLY_OUT_EN - finish after one step when
// |dividend| < |divisor| (results identical to the full run).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start_i           request, sampled only in IDLE
//   signed_i          1 = two's complement operands
//   cancel_i          flush; returns to IDLE on the next edge, no completion
//   dividend_i        dividend, sampled with start_i
//   divisor_i         divisor, sampled with start_i
//   busy_o            high while iterating
//   done_o            one-cycle completion pulse
//   div_by_zero_o     divisor was zero (valid with done_o)
//   result_o          {remainder, quotient}, held until the next completion
module ex_div_iter
  import ex_div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               cancel_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               div_by_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;      // dividend magnitude shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_orig_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dbz_q;
  logic             early_q;
  logic             dbz_out_q;
  logic [2*WIDTH-1:0] result_q;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             early_w;
  logic             accept;
  logic             short_path;
  logic [WIDTH:0]   rem_next;
  logic             quo_bit;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] fin_quo, fin_rem;

  always_comb begin
    dvd_neg = signed_i & dividend_i[WIDTH-1];
    dvs_neg = signed_i & divisor_i[WIDTH-1];
    // MIN negates to itself, which read unsigned is exactly |MIN|.
    dvd_mag = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag = dvs_neg ? -divisor_i : divisor_i;
`ifdef DIV_EARLY_OUT_EN
    early_w = (divisor_i != '0) && (dvd_mag < dvs_mag);
`else
    early_w = 1'b0;
`endif
  end

  assign accept     = (state_q == DIV_IDLE) && start_i && !cancel_i;
  assign short_path = dbz_q | early_q;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_next),
    .quo_bit_o (quo_bit)
  );

  always_comb begin
    quo_next = {quo_q[WIDTH-2:0], quo_bit};
    fin_quo  = neg_quo_q ? -quo_next : quo_next;
    fin_rem  = neg_rem_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    if (cancel_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (start_i) state_d = DIV_BUSY;
        DIV_BUSY: if (short_path || cnt_q == '0) state_d = DIV_DONE;
        DIV_DONE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_orig_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      early_q    <= 1'b0;
      dbz_out_q  <= 1'b0;
      result_q   <= '0;
    end else if (accept) begin
      cnt_q      <= CW'(WIDTH - 1);
      rem_q      <= '0;
      quo_q      <= dvd_mag;
      dvs_q      <= dvs_mag;
      dvd_orig_q <= dividend_i;
      neg_quo_q  <= dvd_neg ^ dvs_neg;
      neg_rem_q  <= dvd_neg;
      dbz_q      <= (divisor_i == '0);
      early_q    <= early_w;
    end else if (state_q == DIV_BUSY && !cancel_i) begin
      if (short_path) begin
        // Both shortcuts return the original dividend as the remainder.
        result_q[DIV_REM_FIELD*WIDTH +: WIDTH] <= dvd_orig_q;
        result_q[DIV_QUO_FIELD*WIDTH +: WIDTH] <= dbz_q ? '1 : '0;
        dbz_out_q <= dbz_q;
      end else begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_q[DIV_REM_FIELD*WIDTH +: WIDTH] <= fin_rem;
          result_q[DIV_QUO_FIELD*WIDTH +: WIDTH] <= fin_quo;
          dbz_out_q <= 1'b0;
        end
      end
    end
  end

  assign busy_o        = (state_q == DIV_BUSY);
  assign done_o        = (state_q == DIV_DONE);
  assign div_by_zero_o = dbz_out_q;
  assign result_o      = result_q;

endmodule
